// File: rtl/cook_sequencer.sv
// Microwave cook-cycle controller: keypad mm:ss entry in BCD, one-second countdown
// from a clock prescaler, magnetron enable in COOK and a timed beeper in DONE.
module cook_sequencer #(
  parameter int CLK_PER_SEC    = 100,
  parameter int DONE_BEEP_SECS = 3
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        door_closed,
  input  logic        start,
  input  logic        stop,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  output logic [15:0] disp_bcd,
  output logic        mag_on,
  output logic        beep,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam int BW = $clog2(DONE_BEEP_SECS + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_SEC - 1);
  localparam logic [BW-1:0] BEEP_LAST = BW'(DONE_BEEP_SECS - 1);

  state_t        st;
  logic [PW-1:0] presc;
  logic [BW-1:0] beep_cnt;
  logic          start_q;

  logic          start_edge;
  logic          can_start;
  logic          key_ok;
  logic          tick;
  logic [PW-1:0] presc_next;
  logic [15:0]   dec_bcd;

  // One-second countdown step; sec_tens reloads with 5, other digits with 9.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] so, stn, mo, mt;
    so  = v[3:0];
    stn = v[7:4];
    mo  = v[11:8];
    mt  = v[15:12];
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (stn != 4'd0) begin
        stn = stn - 4'd1;
      end else begin
        stn = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, stn, so};
  endfunction

  assign start_edge = start && !start_q;
  assign can_start  = start_edge && door_closed && (disp_bcd != 16'h0000);
  assign key_ok     = key_valid && (key_digit <= 4'd9);
  assign tick       = (presc == PRESC_MAX);
  assign presc_next = tick ? '0 : presc + 1'b1;
  assign dec_bcd    = bcd_dec(disp_bcd);

  assign state  = st;
  assign mag_on = (st == COOK);
  assign beep   = (st == DONE);

  always_ff @(posedge clock) begin
    if (clear) begin
      st       <= IDLE;
      disp_bcd <= 16'h0000;
      presc    <= '0;
      beep_cnt <= '0;
      start_q  <= 1'b0;
    end else begin
      start_q <= start;
      case (st)
        IDLE, ENTRY: begin
          // Stop outranks keys even in IDLE, where it otherwise does nothing.
          if (stop) begin
            if (st == ENTRY) begin
              st       <= IDLE;
              disp_bcd <= 16'h0000;
            end
          end else if (st == ENTRY && can_start) begin
            st    <= COOK;
            presc <= '0;
          end else if (key_ok) begin
            disp_bcd <= {disp_bcd[11:0], key_digit};
            st       <= ENTRY;
          end
        end
        COOK: begin
          if (stop || !door_closed) begin
            st <= PAUSE;
          end else begin
            presc <= presc_next;
            if (tick) begin
              disp_bcd <= dec_bcd;
              if (dec_bcd == 16'h0000) begin
                st       <= DONE;
                presc    <= '0;
                beep_cnt <= '0;
              end
            end
          end
        end
        PAUSE: begin
          if (stop) begin
            st       <= IDLE;
            disp_bcd <= 16'h0000;
          end else if (can_start) begin
            st <= COOK;
          end
        end
        DONE: begin
          if (stop) begin
            st <= IDLE;
          end else begin
            presc <= presc_next;
            if (tick) begin
              if (beep_cnt == BEEP_LAST) begin
                st <= IDLE;
              end else begin
                beep_cnt <= beep_cnt + 1'b1;
              end
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cook_sequencer.sv
// Bench for cook_sequencer: keypad vector table, hand-written timing sequences,
// then random stimulus against a digit-array reference model.
module tb_cook_sequencer;
  localparam int CPS = 4;
  localparam int DBS = 3;

  logic        clock = 1'b0;
  logic        clear, door_closed, start, stop, key_valid;
  logic [3:0]  key_digit;
  logic [15:0] disp_bcd;
  logic        mag_on, beep;
  logic [2:0]  state;

  cook_sequencer #(.CLK_PER_SEC(CPS), .DONE_BEEP_SECS(DBS)) dut (
    .clock(clock), .clear(clear), .door_closed(door_closed), .start(start),
    .stop(stop), .key_valid(key_valid), .key_digit(key_digit),
    .disp_bcd(disp_bcd), .mag_on(mag_on), .beep(beep), .state(state)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: state as 0..4, time as a digit array (index 0 = seconds ones).
  int m_state;
  int m_dig[4];
  int m_cyc;
  int m_beeps;
  bit m_prev_start;
  int reload[4] = '{9, 5, 9, 9};

  function automatic logic [15:0] m_disp();
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'(m_dig[i]);
    return r;
  endfunction

  task automatic m_zero();
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
  endtask

  task automatic m_count_down();
    for (int i = 0; i < 4; i++) begin
      if (m_dig[i] > 0) begin
        m_dig[i]--;
        break;
      end
      m_dig[i] = reload[i];
    end
  endtask

  task automatic model_step();
    bit edge_s, nz, second_done;
    edge_s = start && !m_prev_start;
    nz = (m_disp() != 16'h0000);
    second_done = (m_cyc == CPS - 1);
    m_prev_start = start;
    if (clear) begin
      m_state = 0; m_zero(); m_cyc = 0; m_beeps = 0; m_prev_start = 0;
      return;
    end
    case (m_state)
      0, 1: begin
        if (stop) begin
          if (m_state == 1) begin m_state = 0; m_zero(); end
        end else if (m_state == 1 && edge_s && door_closed && nz) begin
          m_state = 2; m_cyc = 0;
        end else if (key_valid && key_digit <= 4'd9) begin
          for (int i = 3; i > 0; i--) m_dig[i] = m_dig[i-1];
          m_dig[0] = int'(key_digit);
          m_state = 1;
        end
      end
      2: begin
        if (stop || !door_closed) m_state = 3;
        else begin
          m_cyc = (m_cyc + 1) % CPS;
          if (second_done) begin
            m_count_down();
            if (m_disp() == 16'h0000) begin m_state = 4; m_cyc = 0; m_beeps = 0; end
          end
        end
      end
      3: begin
        if (stop) begin m_state = 0; m_zero(); end
        else if (edge_s && door_closed && nz) m_state = 2;
      end
      4: begin
        if (stop) m_state = 0;
        else begin
          m_cyc = (m_cyc + 1) % CPS;
          if (second_done) begin
            m_beeps++;
            if (m_beeps == DBS) m_state = 0;
          end
        end
      end
      default: m_state = 0;
    endcase
  endtask

  task automatic cyc();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    clear = 0; door_closed = 1; start = 0; stop = 0; key_valid = 0; key_digit = 0;
  endtask

  task automatic do_clear();
    clear = 1; cyc(); clear = 0;
  endtask

  task automatic enter_time(input logic [15:0] v);
    for (int i = 3; i >= 0; i--) begin
      key_valid = 1; key_digit = v[i*4 +: 4]; cyc();
    end
    key_valid = 0;
  endtask

  task automatic press_start();
    start = 1; cyc(); start = 0;
  endtask

  typedef struct {
    logic        kv;
    logic [3:0]  kd;
    logic        stp;
    logic [15:0] disp;
    logic [2:0]  st;
  } vec_t;

  typedef struct {
    logic [15:0] init;
    logic [15:0] after;
  } dec_t;

  vec_t tbl[6];
  dec_t dtbl[3];

  initial begin
    int cnt, entries;
    logic [2:0] prev_st;

    tbl[0] = '{1'b1, 4'h1, 1'b0, 16'h0001, 3'd1};
    tbl[1] = '{1'b1, 4'h2, 1'b0, 16'h0012, 3'd1};
    tbl[2] = '{1'b1, 4'h3, 1'b0, 16'h0123, 3'd1};
    tbl[3] = '{1'b1, 4'hA, 1'b0, 16'h0123, 3'd1};
    tbl[4] = '{1'b1, 4'h5, 1'b0, 16'h1235, 3'd1};
    tbl[5] = '{1'b0, 4'h0, 1'b1, 16'h0000, 3'd0};
    dtbl[0] = '{16'h0100, 16'h0059};
    dtbl[1] = '{16'h1000, 16'h0959};
    dtbl[2] = '{16'h0090, 16'h0089};

    m_state = 0; m_zero(); m_cyc = 0; m_beeps = 0; m_prev_start = 0;
    quiet();
    do_clear();
    check("reset_state", 32'(state), 32'd0);
    check("reset_disp", 32'(disp_bcd), 32'h0);
    check("reset_mag", 32'(mag_on), 32'd0);
    check("reset_beep", 32'(beep), 32'd0);

    // Keypad entry table, ending with a stop from ENTRY
    for (int i = 0; i < 6; i++) begin
      key_valid = tbl[i].kv; key_digit = tbl[i].kd; stop = tbl[i].stp;
      cyc();
      check($sformatf("key%0d_disp", i), 32'(disp_bcd), 32'(tbl[i].disp));
      check($sformatf("key%0d_state", i), 32'(state), 32'(tbl[i].st));
    end
    quiet();

    // Full cook of 2 seconds, then timed beep
    do_clear();
    enter_time(16'h0002);
    press_start();
    check("cook_state", 32'(state), 32'd2);
    check("cook_mag", 32'(mag_on), 32'd1);
    repeat (3) cyc();
    check("pre_tick_disp", 32'(disp_bcd), 32'h0002);
    cyc();
    check("tick1_disp", 32'(disp_bcd), 32'h0001);
    repeat (4) cyc();
    check("zero_disp", 32'(disp_bcd), 32'h0000);
    check("zero_state", 32'(state), 32'd4);
    cnt = 0;
    while (beep && cnt < 40) begin
      cnt++;
      cyc();
    end
    check("beep_cycles", 32'(cnt), 32'd12);
    check("after_done_state", 32'(state), 32'd0);

    // Borrow chain
    for (int i = 0; i < 3; i++) begin
      do_clear();
      enter_time(dtbl[i].init);
      press_start();
      repeat (4) cyc();
      check($sformatf("borrow%0d", i), 32'(disp_bcd), 32'(dtbl[i].after));
    end

    // Door open mid-second, resume with retained prescaler
    do_clear();
    enter_time(16'h0005);
    press_start();
    repeat (6) cyc();
    check("door_pre_disp", 32'(disp_bcd), 32'h0004);
    door_closed = 0; cyc();
    check("door_pause_state", 32'(state), 32'd3);
    check("door_pause_mag", 32'(mag_on), 32'd0);
    start = 1; cyc(); start = 0;
    check("open_start_state", 32'(state), 32'd3);
    cyc();
    door_closed = 1; cyc();
    press_start();
    check("resume_state", 32'(state), 32'd2);
    cyc();
    check("resume_hold_disp", 32'(disp_bcd), 32'h0004);
    cyc();
    check("resume_tick_disp", 32'(disp_bcd), 32'h0003);

    // Held start gives one COOK entry; stop beats start in PAUSE; start with zero time
    do_clear();
    enter_time(16'h0003);
    entries = 0;
    prev_st = state;
    start = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (state == 3'd2 && prev_st != 3'd2) entries++;
      prev_st = state;
    end
    check("held_start_entries", 32'(entries), 32'd1);
    start = 0; stop = 1; cyc(); stop = 0;
    check("stop_pause_state", 32'(state), 32'd3);
    stop = 1; start = 1; cyc(); stop = 0; start = 0;
    check("stop_start_state", 32'(state), 32'd0);
    check("stop_start_disp", 32'(disp_bcd), 32'h0000);
    cyc();
    press_start();
    check("zero_start_state", 32'(state), 32'd0);

    // Clear mid-cook
    do_clear();
    enter_time(16'h0042);
    press_start();
    repeat (5) cyc();
    do_clear();
    check("midclr_state", 32'(state), 32'd0);
    check("midclr_disp", 32'(disp_bcd), 32'h0000);
    check("midclr_mag", 32'(mag_on), 32'd0);
    check("midclr_beep", 32'(beep), 32'd0);
    press_start();
    check("midclr_start_state", 32'(state), 32'd0);

    // Random stimulus against the model
    do_clear();
    for (int i = 0; i < 3000; i++) begin
      clear       = ($urandom_range(0, 299) == 0);
      door_closed = ($urandom_range(0, 9) != 0);
      start       = ($urandom_range(0, 2) == 0);
      stop        = ($urandom_range(0, 39) == 0);
      key_valid   = ($urandom_range(0, 3) == 0);
      key_digit   = 4'($urandom_range(0, 11));
      cyc();
      check("rand_disp", 32'(disp_bcd), 32'(m_disp()));
      check("rand_state", 32'(state), 32'(m_state));
      check("rand_mag", 32'(mag_on), 32'(m_state == 2));
      check("rand_beep", 32'(beep), 32'(m_state == 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cook_sequencer.md
Name: cook_sequencer

Overview:
- Top-level cook-cycle controller for the microwave oven.
- Accepts keypad digits, a start input, a stop input and the door sensor, and keeps a 4-digit BCD mm:ss cook time.
- Drives the magnetron enable and the end-of-cook beeper.
- Counts time down from an internal clock-cycle prescaler that produces one-second ticks, and sequences IDLE/ENTRY/COOK/PAUSE/DONE.

Parameters:
- CLK_PER_SEC, 100, clock cycles per one-second tick (minimum 2; benches use 4).
- DONE_BEEP_SECS, 3, seconds the beeper stays high in DONE (minimum 1).

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- clear  in  1  synchronous, active-high reset.
- door_closed  in  1  1 = door shut (level).
- start  in  1  start request (level); acted on only at a rising edge (start=1 and the start value sampled in the previous cycle = 0).
- stop  in  1  stop/cancel (level); acted on every cycle it is 1.
- key_valid  in  1  one-cycle strobe qualifying key_digit.
- key_digit  in  4  BCD digit; values greater than 9 are ignored.
- disp_bcd  out  16  {min_tens, min_ones, sec_tens, sec_ones}, registered.
- mag_on  out  1  magnetron enable; equals (state == COOK).
- beep  out  1  beeper; equals (state == DONE).
- state  out  3  IDLE=0, ENTRY=1, COOK=2, PAUSE=3, DONE=4.

Behaviour:
- Reset: clear=1 at a rising edge forces the following, overriding every other input in that cycle:
  - state=IDLE, disp_bcd=0x0000, prescaler=0, beep-second counter=0, start-edge register=0.
  - mag_on and beep therefore read 0 in the next cycle.
- Key entry (IDLE or ENTRY only), when key_valid=1 and key_digit<=9:
  - disp_bcd <= {disp_bcd[11:0], key_digit}, and state -> ENTRY.
  - The oldest digit shifts out; no overflow flag.
  - Keys are ignored in COOK, PAUSE and DONE.
- Start, on a start rising edge with door_closed=1 and disp_bcd != 0:
  - From ENTRY: -> COOK, with prescaler reset to 0.
  - From PAUSE: -> COOK, with prescaler retained.
  - In every other case the edge is ignored, including disp_bcd=0 and door open.
- Stop: COOK -> PAUSE; PAUSE or ENTRY -> IDLE with disp_bcd cleared; DONE -> IDLE; no effect in IDLE.
- Priority within one cycle: clear > stop > door-open > start > key.
  - A key and a start edge in the same ENTRY cycle: start wins and the key is dropped.
- Door: door_closed=0 while in COOK -> PAUSE at the next edge; the prescaler holds its value.
- COOK:
  - Prescaler counts 0..CLK_PER_SEC-1 and wraps to 0.
  - A tick occurs in the cycle where prescaler == CLK_PER_SEC-1.
  - First tick comes CLK_PER_SEC cycles after COOK entry from ENTRY.
  - The prescaler counts only in COOK and DONE.
- BCD decrement on a tick:
  - sec_ones 0 -> 9 with borrow, otherwise -1.
  - Borrow into sec_tens: 0 -> 5 with borrow, otherwise -1.
  - Borrow into min_ones: 0 -> 9 with borrow, otherwise -1.
  - Borrow into min_tens: -1.
  - Entered seconds above 59 (e.g. 0x0090) decrement in plain BCD without normalisation; sec_tens is reloaded only with 5.
- Reaching zero: if the decremented value is 0x0000, state -> DONE in the same edge that writes 0x0000.
  - Prescaler resets to 0 and the beep-second counter resets to 0.
- DONE:
  - Prescaler keeps running; each tick increments the beep-second counter.
  - On the DONE_BEEP_SECS-th tick, state -> IDLE, so beep is high for DONE_BEEP_SECS*CLK_PER_SEC cycles.
  - Door, key and start are ignored; stop exits to IDLE immediately.
- Stop or door in the tick cycle: the state change wins and no decrement happens.
- Reset mid-cook: the next cycle reads IDLE, 0x0000, mag_on=0.
- Encodings 5..7 are unreachable; if decoded, the next state is IDLE.

Test Plan (CLK_PER_SEC=4, DONE_BEEP_SECS=3):
1. Keys 1,2,3 then 0xA then 5 -> disp_bcd 0x0001, 0x0012, 0x0123, unchanged 0x0123, then 0x1235; state ENTRY from the first key.
2. Entry 0x0002, door_closed=1, start pulse:
   - state COOK and mag_on=1 next cycle; 0x0001 after 4 cycles.
   - 0x0000 with state DONE after 8 cycles; beep high exactly 12 cycles, then IDLE.
3. Borrow chain: 0x0100 -> 0x0059 after one tick; 0x1000 -> 0x0959; 0x0090 -> 0x0089.
4. COOK with 0x0005, door_closed=0 after 6 cycles:
   - PAUSE and mag_on=0; start with door open stays in PAUSE.
   - Door closed, then start: COOK resumes with the retained prescaler, so the tick arrives 2 cycles later.
5. Start held high for 10 cycles from ENTRY: only one COOK entry.
   - Stop and start in the same cycle in PAUSE -> IDLE, 0x0000.
   - Start with disp 0x0000 -> stays IDLE.
6. clear=1 mid-COOK at 0x0042 -> next cycle IDLE, 0x0000, mag_on=0, beep=0; a subsequent start edge with no keys is ignored.
